// File: rtl/parc_core_dpath_regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module : parc_regfile_pkg
// Brief  : Shared constants, address-width helper and scoreboard error causes.
// Rev    : 1.0 - initial release
// ============================================================================
package parc_regfile_pkg;

  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_WAW       = 2'd1,
    ERR_SPURIOUS  = 2'd2,
    ERR_WCONFLICT = 2'd3
  } sb_err_cause_e;

endpackage
`default_nettype wire

// File: rtl/parc_core_dpath_regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module : parc_core_dpath_regfile_sb_if
// Brief  : Read, write and scoreboard signals of the register file.
// Rev    : 1.0 - initial release
// ============================================================================
interface parc_core_dpath_regfile_sb_if #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32,
  parameter int NREAD  = 2
);
  import parc_regfile_pkg::*;

  localparam int AW = addr_w(NREGS);

  logic [NREAD*AW-1:0]     raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic [NREAD-1:0]        rbusy;
  logic                    w0_en_p;
  logic [AW-1:0]           w0_addr_p;
  logic [DATA_W-1:0]       w0_data_p;
  logic                    w1_en_p;
  logic [AW-1:0]           w1_addr_p;
  logic [DATA_W-1:0]       w1_data_p;
  logic                    set_en_p;
  logic [AW-1:0]           set_addr_p;
  logic [AW:0]             pend_cnt;
  logic                    sb_err;

  modport master (
    output raddr, w0_en_p, w0_addr_p, w0_data_p,
    output w1_en_p, w1_addr_p, w1_data_p, set_en_p, set_addr_p,
    input  rdata, rbusy, pend_cnt, sb_err
  );

  modport slave (
    input  raddr, w0_en_p, w0_addr_p, w0_data_p,
    input  w1_en_p, w1_addr_p, w1_data_p, set_en_p, set_addr_p,
    output rdata, rbusy, pend_cnt, sb_err
  );

endinterface
`default_nettype wire

// File: rtl/parc_core_dpath_sb.sv
`default_nettype none
// ============================================================================
// Module : parc_core_dpath_sb
// Brief  : Pending-bit scoreboard with population counter and sticky error.
// Rev    : 1.0 - initial release
// ============================================================================
module parc_core_dpath_sb #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w0_en,
  input  logic [AW-1:0]    w0_addr,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] pend,
  output logic [AW:0]      pend_cnt,
  output logic             sb_err
);
  import parc_regfile_pkg::*;

  localparam int CW = AW + 1;

  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic             r_err;
  logic [NREGS-1:0] w_pend_nxt;
  logic             w_set_v;
  logic             w_clr_v;
  logic             w_same;
  logic             w_inc;
  logic             w_dec;
  logic             w_err_waw;
  logic             w_err_spur;
  logic             w_err_conf;
  sb_err_cause_e    w_cause;

  assign w_set_v = set_en && (set_addr != AW'(REG_ZERO));
  assign w_clr_v = clr_en && (clr_addr != AW'(REG_ZERO));
  assign w_same  = w_set_v && w_clr_v && (set_addr == clr_addr);

  // Same-address set+clear is a back-to-back reissue: the bit stays set, count is unchanged.
  assign w_inc = w_set_v && !r_pend[set_addr];
  assign w_dec = w_clr_v && r_pend[clr_addr] && !w_same;

  assign w_err_waw  = w_set_v && r_pend[set_addr] && !w_same;
  assign w_err_spur = w_clr_v && !r_pend[clr_addr] && !w_same;
  assign w_err_conf = w0_en && w_clr_v && (w0_addr == clr_addr);

  always_comb begin
    w_cause = ERR_NONE;
    if (w_err_spur) w_cause = ERR_SPURIOUS;
    if (w_err_waw)  w_cause = ERR_WAW;
    if (w_err_conf) w_cause = ERR_WCONFLICT;
  end

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr_v) w_pend_nxt[clr_addr] = 1'b0;
    if (w_set_v) w_pend_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= r_cnt + CW'(w_inc) - CW'(w_dec);
      if (w_cause != ERR_NONE) r_err <= 1'b1;
    end
  end

  assign pend     = r_pend;
  assign pend_cnt = r_cnt;
  assign sb_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/parc_core_dpath_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module : parc_core_dpath_regfile_sb
// Brief  : Register file with two write ports, scoreboard and optional bypass.
// Rev    : 1.0 - initial release
// ============================================================================
module parc_core_dpath_regfile_sb #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  parc_core_dpath_regfile_sb_if.slave bus
);
  import parc_regfile_pkg::*;

  localparam int AW = addr_w(NREGS);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  w_pend;
  logic              w_w0_v;
  logic              w_w1_v;

  assign w_w0_v = bus.w0_en_p && (bus.w0_addr_p != AW'(REG_ZERO));
  assign w_w1_v = bus.w1_en_p && (bus.w1_addr_p != AW'(REG_ZERO));

  // W0 is applied last so it wins a same-address conflict with W1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      if (w_w1_v) r_regs[bus.w1_addr_p] <= bus.w1_data_p;
      if (w_w0_v) r_regs[bus.w0_addr_p] <= bus.w0_data_p;
    end
  end

  parc_core_dpath_sb #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .w0_en    (w_w0_v),
    .w0_addr  (bus.w0_addr_p),
    .set_en   (bus.set_en_p),
    .set_addr (bus.set_addr_p),
    .clr_en   (bus.w1_en_p),
    .clr_addr (bus.w1_addr_p),
    .pend     (w_pend),
    .pend_cnt (bus.pend_cnt),
    .sb_err   (bus.sb_err)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]     w_ra;
    logic              w_ra_nz;
    logic [DATA_W-1:0] w_stored;

    assign w_ra     = bus.raddr[i*AW +: AW];
    assign w_ra_nz  = (w_ra != AW'(REG_ZERO));
    assign w_stored = w_ra_nz ? r_regs[w_ra] : '0;

    if (BYPASS != 0) begin : g_bypass
      logic w_w0_hit;
      logic w_w1_hit;
      logic w_set_hit;

      assign w_w0_hit  = w_w0_v && (bus.w0_addr_p == w_ra);
      assign w_w1_hit  = w_w1_v && (bus.w1_addr_p == w_ra);
      assign w_set_hit = bus.set_en_p && w_ra_nz && (bus.set_addr_p == w_ra);

      assign bus.rdata[i*DATA_W +: DATA_W] = w_w0_hit ? bus.w0_data_p :
                                             w_w1_hit ? bus.w1_data_p : w_stored;
      assign bus.rbusy[i] = (w_pend[w_ra] && !w_w1_hit) || w_set_hit;
    end else begin : g_nobypass
      assign bus.rdata[i*DATA_W +: DATA_W] = w_stored;
      assign bus.rbusy[i]                  = w_pend[w_ra];
    end
  end

endmodule
`default_nettype wire
